// File: rtl/serv_trap_seq.sv
// serv_trap_seq
// Bit-serial trap/return sequencer feeding the CSR unit's control inputs.
// It decides at each instruction boundary whether a trap is taken
// (exception or latched interrupt), then walks the serial passes that save
// the PC into mepc and load the PC from mtvec. With mret support built in,
// it also walks the single pass that loads the PC from mepc.
//
// Build option:
//   SERV_TRAP_SEQ_MRET_EN - when defined, the RET sequence exists. When
//   undefined, i_mret_req is ignored, o_mret is always 0, and an mret
//   retires like any other instruction.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_insn_done          instruction boundary pulse; causes valid with it
//   i_new_irq            new enabled interrupt pulse from the CSR unit
//   i_e_op               ecall/ebreak
//   i_mem_misalign       misaligned memory access
//   i_mret_req           mret instruction
//   o_busy               sequence in progress, fetch must stall
//   o_cnt_en             serial pass in progress
//   o_cnt0to3/2/3/7      count strobes, only while o_cnt_en
//   o_cnt_done           last bit of a pass
//   o_trap_taken         one-cycle pulse at trap entry
//   o_pending_irq        latched interrupt (mcause[31] source)
//   o_mret               one-cycle pulse on the last bit of the mret pass
//   o_mepc_en/o_mtvec_en CSR register selects
//   o_csr_source         EXT while writing mepc, CSR otherwise
//   o_pc_load            PC takes serial CSR data during this pass
//   o_done               one-cycle pulse when fetch may resume

module serv_trap_seq #(
  parameter int LEN = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_insn_done,
  input  logic       i_new_irq,
  input  logic       i_e_op,
  input  logic       i_mem_misalign,
  input  logic       i_mret_req,
  output logic       o_busy,
  output logic       o_cnt_en,
  output logic       o_cnt0to3,
  output logic       o_cnt2,
  output logic       o_cnt3,
  output logic       o_cnt7,
  output logic       o_cnt_done,
  output logic       o_trap_taken,
  output logic       o_pending_irq,
  output logic       o_mret,
  output logic       o_mepc_en,
  output logic       o_mtvec_en,
  output logic [1:0] o_csr_source,
  output logic       o_pc_load,
  output logic       o_done
);

  localparam int CW = $clog2(LEN);

  localparam logic [1:0] CSR_SOURCE_CSR = 2'b00;
  localparam logic [1:0] CSR_SOURCE_EXT = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    TRAP_EPC,
    TRAP_VEC
`ifdef SERV_TRAP_SEQ_MRET_EN
    , RET
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            pending_irq;
  logic            trap_taken_r;
  logic            done_r;

  logic            cnt_en;
  logic            cnt_last;
  logic            exc;
  logic            trap_now;
  logic            irq_trap;
  logic            done_nxt;
  logic            mret_now;
  logic            mepc_en;
  logic            mtvec_en;
  logic            pc_load;
  logic [1:0]      csr_source;

`ifndef SERV_TRAP_SEQ_MRET_EN
  logic unused_mret_req;
  assign unused_mret_req = i_mret_req;
`endif

  assign exc      = i_e_op | i_mem_misalign;
  assign cnt_last = (cnt == CW'(LEN - 1));

  // Next-state and per-phase CSR controls. An exception always wins over a
  // pending interrupt; in that case irq_trap stays low so the interrupt
  // remains latched for the following boundary.
  always_comb begin
    state_nxt  = state;
    cnt_en     = 1'b0;
    mepc_en    = 1'b0;
    mtvec_en   = 1'b0;
    pc_load    = 1'b0;
    csr_source = CSR_SOURCE_CSR;
    trap_now   = 1'b0;
    irq_trap   = 1'b0;
    done_nxt   = 1'b0;
    mret_now   = 1'b0;
    case (state)
      IDLE: begin
        if (i_insn_done) begin
          if (exc || pending_irq) begin
            state_nxt = TRAP_EPC;
            trap_now  = 1'b1;
            irq_trap  = !exc;
          end
`ifdef SERV_TRAP_SEQ_MRET_EN
          else if (i_mret_req) begin
            state_nxt = RET;
          end
`endif
        end
      end
      TRAP_EPC: begin
        cnt_en     = 1'b1;
        mepc_en    = 1'b1;
        csr_source = CSR_SOURCE_EXT;
        if (cnt_last) state_nxt = TRAP_VEC;
      end
      TRAP_VEC: begin
        cnt_en   = 1'b1;
        mtvec_en = 1'b1;
        pc_load  = 1'b1;
        if (cnt_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
`ifdef SERV_TRAP_SEQ_MRET_EN
      RET: begin
        cnt_en  = 1'b1;
        mepc_en = 1'b1;
        pc_load = 1'b1;
        if (cnt_last) begin
          mret_now  = 1'b1;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State, bit counter and the registered pulses. The counter wraps
  // naturally at LEN-1, so it is already 0 when the next pass begins.
  // A new interrupt sets the latch even while the trap that clears it is
  // being entered, so a back-to-back interrupt is never lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pending_irq  <= 1'b0;
      trap_taken_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state        <= state_nxt;
      if (cnt_en) cnt <= cnt + CW'(1);
      pending_irq  <= i_new_irq | (pending_irq & !(trap_now & irq_trap));
      trap_taken_r <= trap_now;
      done_r       <= done_nxt;
    end
  end

  assign o_busy        = (state != IDLE);
  assign o_cnt_en      = cnt_en;
  assign o_cnt0to3     = cnt_en & (cnt < CW'(4));
  assign o_cnt2        = cnt_en & (cnt == CW'(2));
  assign o_cnt3        = cnt_en & (cnt == CW'(3));
  assign o_cnt7        = cnt_en & (cnt == CW'(7));
  assign o_cnt_done    = cnt_en & cnt_last;
  assign o_trap_taken  = trap_taken_r;
  assign o_pending_irq = pending_irq;
  assign o_mret        = mret_now;
  assign o_mepc_en     = mepc_en;
  assign o_mtvec_en    = mtvec_en;
  assign o_csr_source  = csr_source;
  assign o_pc_load     = pc_load;
  assign o_done        = done_r;

endmodule

// File: tb/tb_serv_trap_seq.sv
// tb_serv_trap_seq
// Directed bench for serv_trap_seq with LEN = 32. Stimulus pushes the
// expected trap/mret/done events into a queue; a monitor pops and compares
// whenever the DUT raises o_trap_taken, o_mret or o_done, and also tallies
// per-pass enables and strobes so each o_done can be checked against the
// expected pass contents.

module tb_serv_trap_seq;

  localparam int LEN = 32;
  localparam logic [1:0] SRC_CSR = 2'b00;
  localparam logic [1:0] SRC_EXT = 2'b01;

  localparam int K_TRAP = 1;
  localparam int K_MRET = 2;
  localparam int K_DONE = 3;

  logic       clk;
  logic       rst;
  logic       insn_done;
  logic       new_irq;
  logic       e_op;
  logic       mem_misalign;
  logic       mret_req;
  logic       busy;
  logic       cnt_en;
  logic       cnt0to3;
  logic       cnt2;
  logic       cnt3;
  logic       cnt7;
  logic       cnt_done;
  logic       trap_taken;
  logic       pending_irq;
  logic       mret;
  logic       mepc_en;
  logic       mtvec_en;
  logic [1:0] csr_source;
  logic       pc_load;
  logic       done;

  serv_trap_seq #(.LEN(LEN)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_insn_done    (insn_done),
    .i_new_irq      (new_irq),
    .i_e_op         (e_op),
    .i_mem_misalign (mem_misalign),
    .i_mret_req     (mret_req),
    .o_busy         (busy),
    .o_cnt_en       (cnt_en),
    .o_cnt0to3      (cnt0to3),
    .o_cnt2         (cnt2),
    .o_cnt3         (cnt3),
    .o_cnt7         (cnt7),
    .o_cnt_done     (cnt_done),
    .o_trap_taken   (trap_taken),
    .o_pending_irq  (pending_irq),
    .o_mret         (mret),
    .o_mepc_en      (mepc_en),
    .o_mtvec_en     (mtvec_en),
    .o_csr_source   (csr_source),
    .o_pc_load      (pc_load),
    .o_done         (done)
  );

  typedef struct {
    int   kind;
    int   cyc;
    logic pend;
    int   epc;
    int   vec;
    int   ret;
    int   c03;
    int   c2;
    int   c3;
    int   c7;
    int   cdone;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int a_epc, a_vec, a_ret, a_c03, a_c2, a_c3, a_c7, a_cdone, a_stray;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_exp(input string name, input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: got unexpected event at cycle %0d, expected none", name, cyc);
    end else begin
      e  = sb.pop_front();
      ok = 1'b1;
      if (e.kind != kind) begin
        errors++;
        $display("[TB] FAIL %s: got event kind %0d, expected kind %0d", name, kind, e.kind);
      end
    end
  endtask

  // Monitor: tally the current pass and compare each event as it appears.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ok;
    if (!busy && !done) begin
      a_epc = 0; a_vec = 0; a_ret = 0; a_c03 = 0; a_c2 = 0;
      a_c3 = 0; a_c7 = 0; a_cdone = 0; a_stray = 0;
    end else begin
      if (mepc_en && cnt_en && csr_source == SRC_EXT && !pc_load) a_epc++;
      if (mtvec_en && cnt_en && csr_source == SRC_CSR && pc_load) a_vec++;
      if (mepc_en && cnt_en && csr_source == SRC_CSR && pc_load) a_ret++;
      a_c03   += int'(cnt0to3);
      a_c2    += int'(cnt2);
      a_c3    += int'(cnt3);
      a_c7    += int'(cnt7);
      a_cdone += int'(cnt_done);
      if (!cnt_en && (cnt0to3 || cnt2 || cnt3 || cnt7 || cnt_done || pc_load || mepc_en || mtvec_en))
        a_stray++;
      if (mepc_en && mtvec_en) a_stray++;
    end
    if (trap_taken) begin
      pop_exp("trap_event", K_TRAP, e, ok);
      if (ok) begin
        cmp("trap_cycle", cyc, e.cyc);
        cmp("trap_pending", pending_irq, e.pend);
        cmp("trap_busy", busy, 1);
      end
    end
    if (mret) begin
      pop_exp("mret_event", K_MRET, e, ok);
      if (ok) cmp("mret_cycle", cyc, e.cyc);
    end
    if (done) begin
      pop_exp("done_event", K_DONE, e, ok);
      if (ok) begin
        cmp("done_cycle", cyc, e.cyc);
        cmp("done_busy", busy, 0);
        cmp("pass_mepc_write", a_epc, e.epc);
        cmp("pass_mtvec_read", a_vec, e.vec);
        cmp("pass_mepc_read", a_ret, e.ret);
        cmp("strobe_cnt0to3", a_c03, e.c03);
        cmp("strobe_cnt2", a_c2, e.c2);
        cmp("strobe_cnt3", a_c3, e.c3);
        cmp("strobe_cnt7", a_c7, e.c7);
        cmp("strobe_cnt_done", a_cdone, e.cdone);
        cmp("stray_enables", a_stray, 0);
      end
    end
  end

  // One boundary cycle with the given causes; kind 1 expects a trap, 2 an
  // mret sequence, 0 nothing. pend is the latch value in the trap cycle.
  task automatic apply_stimulus(input logic eo, input logic mis, input logic mr,
                                input logic irq, input int kind, input logic pend);
    exp_t e;
    int   t0;
    @(negedge clk);
    insn_done    = 1'b1;
    e_op         = eo;
    mem_misalign = mis;
    mret_req     = mr;
    new_irq      = irq;
    t0           = cyc;
    if (kind == 1) begin
      e = '{K_TRAP, t0 + 1, pend, 0, 0, 0, 0, 0, 0, 0, 0};
      sb.push_back(e);
      e = '{K_DONE, t0 + 1 + 2 * LEN, 1'b0, LEN, LEN, 0, 8, 2, 2, 2, 2};
      sb.push_back(e);
    end else if (kind == 2) begin
      e = '{K_MRET, t0 + LEN, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
      sb.push_back(e);
      e = '{K_DONE, t0 + LEN + 1, 1'b0, 0, 0, LEN, 4, 1, 1, 1, 1};
      sb.push_back(e);
    end
    @(negedge clk);
    insn_done    = 1'b0;
    e_op         = 1'b0;
    mem_misalign = 1'b0;
    mret_req     = 1'b0;
    new_irq      = 1'b0;
  endtask

  task automatic pulse_irq();
    @(negedge clk);
    new_irq = 1'b1;
    @(negedge clk);
    new_irq = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    cmp({name, "_timeout"}, (n < limit), 1);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag);
    cmp({tag, "_busy"}, busy, 0);
    cmp({tag, "_cnt_en"}, cnt_en, 0);
    cmp({tag, "_strobes"}, {cnt0to3, cnt2, cnt3, cnt7, cnt_done}, 0);
    cmp({tag, "_trap_taken"}, trap_taken, 0);
    cmp({tag, "_pending"}, pending_irq, 0);
    cmp({tag, "_mret"}, mret, 0);
    cmp({tag, "_csr_en"}, {mepc_en, mtvec_en}, 0);
    cmp({tag, "_csr_source"}, csr_source, SRC_CSR);
    cmp({tag, "_pc_load"}, pc_load, 0);
    cmp({tag, "_done"}, done, 0);
  endtask

  initial begin : stim
    int n;
    rst          = 1'b1;
    insn_done    = 1'b0;
    new_irq      = 1'b0;
    e_op         = 1'b0;
    mem_misalign = 1'b0;
    mret_req     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_output("reset");

    // ecall trap; a boundary pulse while busy must be ignored
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    repeat (20) @(negedge clk);
    insn_done = 1'b1;
    e_op      = 1'b1;
    @(negedge clk);
    insn_done = 1'b0;
    e_op      = 1'b0;
    wait_done("ecall", 200);
    check_output("after_ecall");

    // interrupt latched off-boundary, taken at the next boundary
    pulse_irq();
    repeat (4) @(negedge clk);
    cmp("irq_latched", pending_irq, 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    wait_done("irq", 200);

    // interrupt with a misaligned access: exception first, irq stays pending
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1);
    wait_done("misalign", 200);
    cmp("irq_held_after_exc", pending_irq, 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    repeat (10) @(negedge clk);
    pulse_irq();
    wait_done("irq2", 200);
    cmp("irq_held_while_busy", pending_irq, 1);
    // set and clear together: latch stays set
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    wait_done("irq_setwins", 200);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    wait_done("irq3", 200);
    cmp("irq_cleared", pending_irq, 0);

`ifdef SERV_TRAP_SEQ_MRET_EN
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0);
    wait_done("mret", 200);
`else
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || mret) n++;
    end
    cmp("mret_ignored", n, 0);
`endif
    // exception beats mret
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    wait_done("exc_over_mret", 200);

    // reset in the middle of the mepc pass, at count 10
    pulse_irq();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    repeat (10) @(negedge clk);
    cmp("pre_reset_mepc_pass", {cnt_en, mepc_en}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    cmp("rst_busy", busy, 0);
    cmp("rst_cnt_en", cnt_en, 0);
    cmp("rst_pending", pending_irq, 0);
    cmp("rst_done", done, 0);
    rst = 1'b0;
    // the cancelled sequence's completion will never come
    void'(sb.pop_back());
    n = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) n++;
    end
    cmp("no_done_after_reset", n, 0);
    // a fresh trap must start its count from zero
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    wait_done("post_reset", 200);

    cmp("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
